// File: rtl/priority_encoder.sv
// Lowest-set-bit priority encoder with hit and multi-hit flags.
// Outputs are either registered (one-cycle latency) or driven combinationally from the input.
module priority_encoder #(
    parameter int OUT_WIDTH = 3,
    parameter int REG_OUT   = 1
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        en,
    input  logic [(1 << OUT_WIDTH)-1:0] in,
    output logic [OUT_WIDTH-1:0]        out,
    output logic                        hit,
    output logic                        multi
);

    localparam int IN_WIDTH = 1 << OUT_WIDTH;
    localparam int ENC_W    = OUT_WIDTH + 2;

    // Pairwise reduction tree, log2(IN_WIDTH) levels, done in place.
    // Node n at level lvl merges children 2n (lower indices) and 2n+1.
    // The lower child wins whenever it has any bit set.
    // The index of an empty node is kept at 0, so an all-zero input encodes to 0.
    function automatic logic [ENC_W-1:0] encode(input logic [IN_WIDTH-1:0] vec);
        logic [IN_WIDTH-1:0]                anyV;
        logic [IN_WIDTH-1:0]                multiV;
        logic [IN_WIDTH-1:0][OUT_WIDTH-1:0] idxV;
        logic                               loAny;
        logic                               hiAny;
        anyV   = vec;
        multiV = '0;
        idxV   = '0;
        loAny  = 1'b0;
        hiAny  = 1'b0;
        for (int lvl = 1; lvl <= OUT_WIDTH; lvl++) begin
            for (int n = 0; n < (IN_WIDTH >> lvl); n++) begin
                loAny             = anyV[2*n];
                hiAny             = anyV[2*n+1];
                multiV[n]         = multiV[2*n] | multiV[2*n+1] | (loAny & hiAny);
                idxV[n]           = loAny ? idxV[2*n] : idxV[2*n+1];
                idxV[n][lvl-1]    = ~loAny & hiAny;
                anyV[n]           = loAny | hiAny;
            end
        end
        return {idxV[0], anyV[0], multiV[0]};
    endfunction

    logic [ENC_W-1:0]     enc;
    logic [OUT_WIDTH-1:0] encIdx;
    logic                 encHit;
    logic                 encMulti;

    assign enc      = encode(in);
    assign encIdx   = enc[ENC_W-1:2];
    assign encHit   = enc[1];
    assign encMulti = enc[0];

    if (REG_OUT != 0) begin : gRegOut
        logic [OUT_WIDTH-1:0] outQ;
        logic                 hitQ;
        logic                 multiQ;

        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                outQ   <= '0;
                hitQ   <= 1'b0;
                multiQ <= 1'b0;
            end else if (en) begin
                outQ   <= encIdx;
                hitQ   <= encHit;
                multiQ <= encMulti;
            end
        end

        assign out   = outQ;
        assign hit   = hitQ;
        assign multi = multiQ;
    end else begin : gCombOut
        // Clock, reset and enable have no effect in this mode.
        logic unusedCtrl;
        assign unusedCtrl = ^{clk, res, en};

        assign out   = encIdx;
        assign hit   = encHit;
        assign multi = encMulti;
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed and exhaustive checks of priority_encoder across widths and output modes.
module tb_priority_encoder;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  in3;
    logic [1:0]  in1;
    logic [15:0] in4;

    logic [2:0] out3r, out3c;
    logic       hit3r, multi3r, hit3c, multi3c;
    logic [0:0] out1r, out1c;
    logic       hit1r, multi1r, hit1c, multi1c;
    logic [3:0] out4r, out4c;
    logic       hit4r, multi4r, hit4c, multi4c;

    int nCmp = 0;
    int nBad = 0;

    priority_encoder #(.OUT_WIDTH(3), .REG_OUT(1)) u3r (
        .clk(clk), .res(res), .en(en), .in(in3), .out(out3r), .hit(hit3r), .multi(multi3r));
    priority_encoder #(.OUT_WIDTH(3), .REG_OUT(0)) u3c (
        .clk(clk), .res(res), .en(en), .in(in3), .out(out3c), .hit(hit3c), .multi(multi3c));
    priority_encoder #(.OUT_WIDTH(1), .REG_OUT(1)) u1r (
        .clk(clk), .res(res), .en(en), .in(in1), .out(out1r), .hit(hit1r), .multi(multi1r));
    priority_encoder #(.OUT_WIDTH(1), .REG_OUT(0)) u1c (
        .clk(clk), .res(res), .en(en), .in(in1), .out(out1c), .hit(hit1c), .multi(multi1c));
    priority_encoder #(.OUT_WIDTH(4), .REG_OUT(1)) u4r (
        .clk(clk), .res(res), .en(en), .in(in4), .out(out4r), .hit(hit4r), .multi(multi4r));
    priority_encoder #(.OUT_WIDTH(4), .REG_OUT(0)) u4c (
        .clk(clk), .res(res), .en(en), .in(in4), .out(out4c), .hit(hit4c), .multi(multi4c));

    // Packs {index, hit, multi} into one comparable word.
    function automatic logic [5:0] pack(input int o, input logic h, input logic m);
        logic [3:0] o4;
        o4 = o[3:0];
        return {o4, h, m};
    endfunction

    // Linear-scan reference over the low w bits of v.
    function automatic logic [5:0] model(input logic [15:0] v, input int w);
        int idx = 0;
        int cnt = 0;
        for (int i = w - 1; i >= 0; i--) if (v[i]) idx = i;
        for (int i = 0; i < w; i++) cnt += int'(v[i]);
        return pack(idx, cnt != 0, cnt >= 2);
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed idx=%0d hit=%0b multi=%0b, expected idx=%0d hit=%0b multi=%0b",
                   tag, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in3 = '0;
        in1 = '0;
        in4 = '0;
        #1 res = 1'b1;
        #1;
        check("reset3r", {1'b0, out3r, hit3r, multi3r}, pack(0, 0, 0));
        check("reset1r", {3'b0, out1r, hit1r, multi1r}, pack(0, 0, 0));
        check("reset4r", {out4r, hit4r, multi4r}, pack(0, 0, 0));

        // Reset dominates enable and input across a clock edge.
        en  = 1'b1;
        in3 = 8'h04;
        in1 = 2'b10;
        #1;
        check("comb3_04", {1'b0, out3c, hit3c, multi3c}, pack(2, 1, 0));
        check("comb1_10", {3'b0, out1c, hit1c, multi1c}, pack(1, 1, 0));
        tick();
        check("resHold3", {1'b0, out3r, hit3r, multi3r}, pack(0, 0, 0));
        res = 1'b0;
        tick();
        check("first3_04", {1'b0, out3r, hit3r, multi3r}, pack(2, 1, 0));
        check("first1_10", {3'b0, out1r, hit1r, multi1r}, pack(1, 1, 0));

        in1 = 2'b11;
        #1;
        check("comb1_11", {3'b0, out1c, hit1c, multi1c}, pack(0, 1, 1));
        tick();
        check("reg1_11", {3'b0, out1r, hit1r, multi1r}, pack(0, 1, 1));

        // One-hot sweep: output lags input by exactly one edge.
        for (int k = 0; k < 8; k++) begin
            in3 = 8'(1 << k);
            #1;
            check("sweepPre", {1'b0, out3r, hit3r, multi3r}, pack((k == 0) ? 2 : k - 1, 1, 0));
            tick();
            check("sweepPost", {1'b0, out3r, hit3r, multi3r}, pack(k, 1, 0));
        end

        in3 = 8'h00; tick();
        check("zero", {1'b0, out3r, hit3r, multi3r}, pack(0, 0, 0));
        in3 = 8'h80; tick();
        check("top80", {1'b0, out3r, hit3r, multi3r}, pack(7, 1, 0));
        in3 = 8'h90; tick();
        check("pair90", {1'b0, out3r, hit3r, multi3r}, pack(4, 1, 1));
        in3 = 8'hFF; tick();
        check("allFF", {1'b0, out3r, hit3r, multi3r}, pack(0, 1, 1));

        // Enable low holds the captured value.
        in3 = 8'h20; tick();
        check("cap20", {1'b0, out3r, hit3r, multi3r}, pack(5, 1, 0));
        en  = 1'b0;
        in3 = 8'h02;
        tick();
        check("hold1", {1'b0, out3r, hit3r, multi3r}, pack(5, 1, 0));
        tick();
        check("hold2", {1'b0, out3r, hit3r, multi3r}, pack(5, 1, 0));
        en = 1'b1;
        tick();
        check("resume02", {1'b0, out3r, hit3r, multi3r}, pack(1, 1, 0));

        // Asynchronous reset between edges.
        in3 = 8'h20; tick();
        check("preRes", {1'b0, out3r, hit3r, multi3r}, pack(5, 1, 0));
        #3 res = 1'b1;
        #1;
        check("asyncRes", {1'b0, out3r, hit3r, multi3r}, pack(0, 0, 0));
        in3 = 8'h08;
        tick();
        check("resEdge1", {1'b0, out3r, hit3r, multi3r}, pack(0, 0, 0));
        tick();
        check("resEdge2", {1'b0, out3r, hit3r, multi3r}, pack(0, 0, 0));
        res = 1'b0;
        tick();
        check("postRes", {1'b0, out3r, hit3r, multi3r}, pack(3, 1, 0));

        // Exhaustive for widths 1 and 3, mixed 16-bit patterns for width 4 registered.
        for (int v = 0; v < 256; v++) begin
            in3 = v[7:0];
            in1 = v[1:0];
            in4 = 16'((v * 257) ^ (1 << (v % 16)));
            #1;
            check("exComb3", {1'b0, out3c, hit3c, multi3c}, model({8'h00, in3}, 8));
            check("exComb1", {3'b0, out1c, hit1c, multi1c}, model({14'h0, in1}, 2));
            tick();
            check("exReg3", {1'b0, out3r, hit3r, multi3r}, model({8'h00, in3}, 8));
            check("exReg1", {3'b0, out1r, hit1r, multi1r}, model({14'h0, in1}, 2));
            check("exReg4", {out4r, hit4r, multi4r}, model(in4, 16));
        end

        for (int v = 0; v < 65536; v++) begin
            in4 = v[15:0];
            #1;
            check("exComb4", {out4c, hit4c, multi4c}, model(in4, 16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
